classify_ctrl: RTL and testbench



---
 rtl/classify_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_classify_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/classify_ctrl.sv
// classify_ctrl: sequencing controller for the k-means classification datapath.
// Loads initial centroids, streams points into pipe1, drives centroid update
// writes, then iterates until the convergence checker or the iteration limit
// ends the run.
module classify_ctrl #(
    parameter int unsigned addrWidth    = 8,
    parameter int unsigned centroid_num = 8,
    parameter int unsigned iter_width   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [3:0]                      k_num,
    input  logic [addrWidth-1:0]            last_addr,
    input  logic [iter_width-1:0]           max_iter,
    input  logic                            core_cent_valid,
    input  logic                            new_cent_valid,
    input  logic                            conv_valid,
    input  logic                            converged,
    output logic                            ram_rd_en,
    output logic [addrWidth-1:0]            ram_addr,
    output logic                            input_reg_en,
    output logic                            first_iteration,
    output logic [centroid_num-1:0]         centroid_en,
    output logic [$clog2(centroid_num)-1:0] cent_cnt,
    output logic                            accum_clr,
    output logic                            accum_en,
    output logic                            busy,
    output logic                            done,
    output logic [iter_width-1:0]           iter_cnt
);

    localparam int unsigned CntW = $clog2(centroid_num);

    typedef enum logic [2:0] {
        StIdle, StLoad, StClear, StRead, StDrain, StUpdate, StCheck, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            k_lat_q, k_lat_d;
    logic [addrWidth-1:0]  last_q, last_d;
    logic [addrWidth-1:0]  pt_idx_q, pt_idx_d;
    logic [iter_width-1:0] max_q, max_d;
    logic [iter_width-1:0] iter_q, iter_d;
    logic [CntW-1:0]       k_idx_q, k_idx_d;
    logic                  drain_q, drain_d;
    logic                  ire_q;
    logic                  accum_en_q;
    logic                  k_last;
    logic                  iter_last;
    logic [3:0]            k_clip;
    logic [iter_width-1:0] max_clip;

    // k_idx is pointing at the last active centroid
    assign k_last    = (32'(k_idx_q) + 32'd1 == 32'(k_lat_q));
    // the pass now being checked is the final one allowed
    assign iter_last = (32'(iter_q) + 32'd1 >= 32'(max_q));

    // Clip the run parameters sampled at start.
    always_comb begin
        k_clip = k_num;
        if (k_num == 4'd0) begin
            k_clip = 4'd1;
        end else if (32'(k_num) > centroid_num) begin
            k_clip = 4'(centroid_num);
        end
        max_clip = (max_iter == '0) ? iter_width'(1) : max_iter;
    end

    // Next-state logic for the sequencing FSM and its counters.
    always_comb begin
        state_d  = state_q;
        k_lat_d  = k_lat_q;
        last_d   = last_q;
        max_d    = max_q;
        iter_d   = iter_q;
        k_idx_d  = k_idx_q;
        pt_idx_d = pt_idx_q;
        drain_d  = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_lat_d = k_clip;
                    last_d  = last_addr;
                    max_d   = max_clip;
                    iter_d  = '0;
                    k_idx_d = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (core_cent_valid) begin
                    k_idx_d = k_idx_q + 1'b1;
                    if (k_last) begin
                        k_idx_d = '0;
                        state_d = StClear;
                    end
                end
            end
            StClear: begin
                pt_idx_d = '0;
                state_d  = StRead;
            end
            StRead: begin
                pt_idx_d = pt_idx_q + 1'b1;
                if (pt_idx_q == last_q) begin
                    drain_d = 1'b0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    k_idx_d = '0;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                if (new_cent_valid) begin
                    k_idx_d = k_idx_q + 1'b1;
                    if (k_last) begin
                        k_idx_d = '0;
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (conv_valid) begin
                    if (iter_q < max_q) begin
                        iter_d = iter_q + 1'b1;
                    end
                    state_d = (converged || iter_last) ? StDone : StClear;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; centroid enables follow their valids directly.
    always_comb begin
        ram_rd_en       = (state_q == StRead);
        ram_addr        = ram_rd_en ? pt_idx_q : '0;
        first_iteration = (state_q == StLoad);
        accum_clr       = (state_q == StClear);
        busy            = (state_q != StIdle);
        done            = (state_q == StDone);
        cent_cnt        = (state_q == StUpdate) ? k_idx_q : '0;
        centroid_en     = '0;
        if ((state_q == StLoad && core_cent_valid) || (state_q == StUpdate && new_cent_valid)) begin
            centroid_en[k_idx_q] = 1'b1;
        end
    end

    assign input_reg_en = ire_q;
    assign accum_en     = accum_en_q;
    assign iter_cnt     = iter_q;

    // State register plus the RAM-latency pipeline of read strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            k_lat_q    <= '0;
            last_q     <= '0;
            pt_idx_q   <= '0;
            max_q      <= '0;
            iter_q     <= '0;
            k_idx_q    <= '0;
            drain_q    <= 1'b0;
            ire_q      <= 1'b0;
            accum_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_lat_q    <= k_lat_d;
            last_q     <= last_d;
            pt_idx_q   <= pt_idx_d;
            max_q      <= max_d;
            iter_q     <= iter_d;
            k_idx_q    <= k_idx_d;
            drain_q    <= drain_d;
            ire_q      <= ram_rd_en;
            accum_en_q <= ire_q;
        end
    end

endmodule

// File: tb/tb_classify_ctrl.sv
// Self-checking bench for classify_ctrl: directed and randomized runs compared
// against an event-level model of a whole classification run.
module tb_classify_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned CN = 8;
    localparam int unsigned IW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    k_num = '0;
    logic [AW-1:0] last_addr = '0;
    logic [IW-1:0] max_iter = '0;
    logic          core_cent_valid = 1'b0;
    logic          new_cent_valid = 1'b0;
    logic          conv_valid = 1'b0;
    logic          converged = 1'b0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic          input_reg_en;
    logic          first_iteration;
    logic [CN-1:0] centroid_en;
    logic [2:0]    cent_cnt;
    logic          accum_clr;
    logic          accum_en;
    logic          busy;
    logic          done;
    logic [IW-1:0] iter_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    classify_ctrl #(
        .addrWidth   (AW),
        .centroid_num(CN),
        .iter_width  (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .k_num          (k_num),
        .last_addr      (last_addr),
        .max_iter       (max_iter),
        .core_cent_valid(core_cent_valid),
        .new_cent_valid (new_cent_valid),
        .conv_valid     (conv_valid),
        .converged      (converged),
        .ram_rd_en      (ram_rd_en),
        .ram_addr       (ram_addr),
        .input_reg_en   (input_reg_en),
        .first_iteration(first_iteration),
        .centroid_en    (centroid_en),
        .cent_cnt       (cent_cnt),
        .accum_clr      (accum_clr),
        .accum_en       (accum_en),
        .busy           (busy),
        .done           (done),
        .iter_cnt       (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run from start to done. The model works on whole events:
    // which centroid writes, reads and passes a run must contain.
    task automatic run_one(input int kn, input int la, input int mi, input int conv_at,
                           input bit gaps);
        int k, mx, iters, clr_n, done_n, busy_n, cyc, exp_busy;
        logic [CN-1:0] load_q[$];
        logic [CN-1:0] upd_q[$];
        int rd_q[$];
        logic prev_rd, prev_ire;
        k     = (kn == 0) ? 1 : ((kn > int'(CN)) ? int'(CN) : kn);
        mx    = (mi == 0) ? 1 : mi;
        iters = (conv_at + 1 < mx) ? conv_at + 1 : mx;
        clr_n = 0; done_n = 0; busy_n = 0; cyc = 0;
        prev_rd = 1'b0; prev_ire = 1'b0;
        k_num = 4'(kn); last_addr = AW'(la); max_iter = IW'(mi);
        while (done_n == 0 && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) begin
                start = 1'b1;
            end else if (busy && !done && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
            end
            core_cent_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            new_cent_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            conv_valid      = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            converged       = (clr_n == conv_at + 1);
            #1;
            check("input_reg_en_lag", input_reg_en, prev_rd);
            check("accum_en_lag", accum_en, prev_ire);
            prev_rd  = ram_rd_en;
            prev_ire = input_reg_en;
            if (centroid_en != '0) begin
                if (first_iteration) begin
                    check("load_needs_valid", core_cent_valid, 1);
                    load_q.push_back(centroid_en);
                end else begin
                    check("update_needs_valid", new_cent_valid, 1);
                    check("update_en_vs_cnt", centroid_en, 64'(1) << cent_cnt);
                    upd_q.push_back(centroid_en);
                end
            end
            if (ram_rd_en) rd_q.push_back(int'(ram_addr));
            if (accum_clr) clr_n++;
            if (busy) busy_n++;
            if (done) done_n++;
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done_n, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            core_cent_valid = 1'($urandom_range(0, 1));
            new_cent_valid  = 1'($urandom_range(0, 1));
            conv_valid      = 1'($urandom_range(0, 1));
            #1;
            check("idle_quiet", {busy, done, centroid_en, ram_rd_en, accum_clr}, 0);
        end
        check("load_count", load_q.size(), k);
        foreach (load_q[i]) check("load_en", load_q[i], 64'(1) << i);
        check("update_count", upd_q.size(), k * iters);
        foreach (upd_q[i]) check("update_en", upd_q[i], 64'(1) << (i % k));
        check("read_count", rd_q.size(), iters * (la + 1));
        foreach (rd_q[i]) check("read_addr", rd_q[i], i % (la + 1));
        check("clear_count", clr_n, iters);
        check("iter_cnt_held", iter_cnt, iters);
        if (!gaps) begin
            exp_busy = k + iters * (1 + (la + 1) + 2 + k + 1) + 1;
            check("busy_cycles", busy_n, exp_busy);
        end
        core_cent_valid = 1'b0; new_cent_valid = 1'b0; conv_valid = 1'b0; converged = 1'b0;
    endtask

    initial begin
        int waited;
        bit found;
        #1;
        check("reset_out_a", {ram_rd_en, ram_addr, input_reg_en, first_iteration, centroid_en}, 0);
        check("reset_out_b", {cent_cnt, accum_clr, accum_en, busy, done, iter_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one(3, 4, 5, 0, 1'b0);    // basic run, converge on first check
        run_one(3, 4, 3, 99, 1'b0);   // iteration limit
        run_one(0, 0, 2, 0, 1'b1);    // k_num 0, single point, gapped valids
        run_one(12, 6, 2, 0, 1'b0);   // k_num clipped to 8
        run_one(2, 3, 0, 5, 1'b1);    // max_iter 0 acts as 1

        // Reset while reading address 2.
        @(negedge clk);
        k_num = 4'd3; last_addr = 8'd6; max_iter = 8'd2; start = 1'b1;
        core_cent_valid = 1'b1; new_cent_valid = 1'b1; conv_valid = 1'b1; converged = 1'b0;
        waited = 0; found = 1'b0;
        while (!found && waited < 200) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            found = ram_rd_en && (ram_addr == 8'd2);
            waited++;
        end
        check("reach_addr2", found, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_a", {ram_rd_en, ram_addr, input_reg_en, first_iteration, centroid_en}, 0);
        check("midrst_out_b", {cent_cnt, accum_clr, accum_en, busy, done, iter_cnt}, 0);
        core_cent_valid = 1'b0; new_cent_valid = 1'b0; conv_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_one(3, 5, 2, 99, 1'b0);

        for (int r = 0; r < 10; r++) begin
            run_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
